// File: rtl/sram_stream_adapter.sv
// sram_stream_adapter: valid/ready request stream to single-port SRAM macro
// front end. A Latency-deep tag pipeline follows each accepted request to the
// macro's read-data return. A fall-through response FIFO returns one in-order
// response per request. The outstanding-request credit keeps the FIFO from
// overflowing when the response port applies back-pressure.
module sram_stream_adapter #(
  parameter  int NumWords  = 1024,
  parameter  int DataWidth = 32,
  parameter  int ByteWidth = 8,
  parameter  int Latency   = 1,
  parameter  int RspDepth  = 2,
  localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_we_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int CntWidth = $clog2(RspDepth + 1);
  localparam int PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;

  // A zero-latency macro or a zero-entry buffer cannot be tracked.
  if (Latency < 1) begin : g_bad_latency
    $fatal(1, "sram_stream_adapter: Latency must be >= 1");
  end
  if (RspDepth < 1) begin : g_bad_depth
    $fatal(1, "sram_stream_adapter: RspDepth must be >= 1");
  end

  logic [CntWidth-1:0]  out_cnt_q, out_cnt_d;
  logic [Latency-1:0]   vld_pipe_q, vld_pipe_d;
  logic [Latency-1:0]   we_pipe_q, we_pipe_d;
  logic [DataWidth-1:0] fifo_data_q [RspDepth];
  logic [DataWidth-1:0] fifo_data_d [RspDepth];
  logic                 fifo_we_q   [RspDepth];
  logic                 fifo_we_d   [RspDepth];
  logic [PtrWidth-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntWidth-1:0]  fcnt_q, fcnt_d;

  logic                 accept, push, push_we, pop;
  logic                 fifo_empty, fifo_full, bypass, store, adv_rd;
  logic [DataWidth-1:0] push_data;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(RspDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit is a function of registered state only, never of the rsp port.
  assign req_ready_o  = (out_cnt_q < CntWidth'(RspDepth));
  assign accept       = req_valid_i & req_ready_o;

  assign sram_req_o   = accept;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  // Pipeline tail lines up with the macro's read data; writes return zero.
  assign push       = vld_pipe_q[Latency-1];
  assign push_we    = we_pipe_q[Latency-1];
  assign push_data  = push_we ? '0 : sram_rdata_i;

  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == CntWidth'(RspDepth));

  // Fall-through: an empty FIFO presents the incoming push directly.
  assign rsp_valid_o = ~fifo_empty | push;
  assign rsp_rdata_o = ~fifo_empty ? fifo_data_q[rptr_q] : (push ? push_data : '0);
  assign rsp_we_o    = ~fifo_empty ? fifo_we_q[rptr_q]   : (push & push_we);
  assign pop         = rsp_valid_o & rsp_ready_i;

  // A push that is popped straight through never touches storage.
  assign bypass = fifo_empty & push & pop;
  assign store  = push & ~bypass;
  assign adv_rd = pop & ~bypass;

  // Next state: tag pipeline, FIFO storage/pointers, outstanding credit.
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    we_pipe_d     = we_pipe_q;
    vld_pipe_d[0] = accept;
    we_pipe_d[0]  = req_we_i;
    for (int i = 1; i < Latency; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      we_pipe_d[i]  = we_pipe_q[i-1];
    end

    fifo_data_d = fifo_data_q;
    fifo_we_d   = fifo_we_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    if (store) begin
      fifo_data_d[wptr_q] = push_data;
      fifo_we_d[wptr_q]   = push_we;
      wptr_d              = ptr_inc(wptr_q);
    end
    if (adv_rd) rptr_d = ptr_inc(rptr_q);
    fcnt_d = fcnt_q + CntWidth'(store) - CntWidth'(adv_rd);

    out_cnt_d = out_cnt_q;
    case ({accept, pop})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // State registers; reset drops every in-flight and buffered response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt_q  <= '0;
      vld_pipe_q <= '0;
      we_pipe_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fcnt_q     <= '0;
      for (int i = 0; i < RspDepth; i++) begin
        fifo_data_q[i] <= '0;
        fifo_we_q[i]   <= 1'b0;
      end
    end else begin
      out_cnt_q   <= out_cnt_d;
      vld_pipe_q  <= vld_pipe_d;
      we_pipe_q   <= we_pipe_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fcnt_q      <= fcnt_d;
      fifo_data_q <= fifo_data_d;
      fifo_we_q   <= fifo_we_d;
    end
  end

  // Credit accounting must make a push into a full, non-draining FIFO impossible.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_sram_stream_adapter.sv
// Directed + scoreboard bench for sram_stream_adapter.
// Instance a: Latency=1, RspDepth=2. Instance b: Latency=2, RspDepth=3 (streaming).
module tb_sram_stream_adapter;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // instance a signals
  logic          a_req_valid, a_req_ready, a_req_we;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata;
  logic [BW-1:0] a_req_be;
  logic          a_rsp_valid, a_rsp_ready, a_rsp_we;
  logic [DW-1:0] a_rsp_rdata;
  logic          a_sram_req, a_sram_we;
  logic [AW-1:0] a_sram_addr;
  logic [DW-1:0] a_sram_wdata, a_sram_rdata;
  logic [BW-1:0] a_sram_be;

  // instance b signals
  logic          b_req_valid, b_req_ready, b_req_we;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata;
  logic [BW-1:0] b_req_be;
  logic          b_rsp_valid, b_rsp_ready, b_rsp_we;
  logic [DW-1:0] b_rsp_rdata;
  logic          b_sram_req, b_sram_we;
  logic [AW-1:0] b_sram_addr;
  logic [DW-1:0] b_sram_wdata, b_sram_rdata;
  logic [BW-1:0] b_sram_be;

  sram_stream_adapter #(.NumWords(1024), .DataWidth(DW), .ByteWidth(8),
                        .Latency(1), .RspDepth(2)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
    .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata), .req_be_i(a_req_be),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
    .rsp_rdata_o(a_rsp_rdata), .rsp_we_o(a_rsp_we),
    .sram_req_o(a_sram_req), .sram_we_o(a_sram_we), .sram_addr_o(a_sram_addr),
    .sram_wdata_o(a_sram_wdata), .sram_be_o(a_sram_be), .sram_rdata_i(a_sram_rdata)
  );

  sram_stream_adapter #(.NumWords(1024), .DataWidth(DW), .ByteWidth(8),
                        .Latency(2), .RspDepth(3)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_be_i(b_req_be),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_rdata_o(b_rsp_rdata), .rsp_we_o(b_rsp_we),
    .sram_req_o(b_sram_req), .sram_we_o(b_sram_we), .sram_addr_o(b_sram_addr),
    .sram_wdata_o(b_sram_wdata), .sram_be_o(b_sram_be), .sram_rdata_i(b_sram_rdata)
  );

  // Macro model a: 16 words, latency 1, byte-enabled writes.
  logic [DW-1:0] m1 [16];
  initial for (int i = 0; i < 16; i++) m1[i] = 32'h5A00_0000 | i;
  always @(posedge clk) begin
    if (a_sram_req) begin
      if (a_sram_we) begin
        for (int k = 0; k < BW; k++)
          if (a_sram_be[k]) m1[a_sram_addr[3:0]][k*8 +: 8] <= a_sram_wdata[k*8 +: 8];
      end else begin
        a_sram_rdata <= m1[a_sram_addr[3:0]];
      end
    end
  end

  // Macro model b: read-only pattern A000_0000|addr, latency 2.
  logic [DW-1:0] b_r1;
  always @(posedge clk) begin
    if (b_sram_req && !b_sram_we) b_r1 <= 32'hA000_0000 | 32'(b_sram_addr);
    b_sram_rdata <= b_r1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_a(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [BW-1:0] be);
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = data;
    a_req_be    = be;
  endtask

  logic [32:0]   exp_q[$];
  logic [32:0]   e;
  logic [DW-1:0] ref_mem [16];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
    a_rsp_ready = 1;
    b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    b_rsp_ready = 1;
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    // reset state
    chk("rst_ready",    32'(a_req_ready), 1);
    chk("rst_valid",    32'(a_rsp_valid), 0);
    chk("rst_rdata",    a_rsp_rdata, 0);
    chk("rst_we",       32'(a_rsp_we), 0);
    chk("rst_sram_req", 32'(a_sram_req), 0);
    chk("rst_b_ready",  32'(b_req_ready), 1);
    rst_n = 1;
    step();

    // write then read, addr 5
    drive_a(1'b1, 10'd5, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk("wr_sram_req",   32'(a_sram_req), 1);
    chk("wr_sram_we",    32'(a_sram_we), 1);
    chk("wr_sram_addr",  32'(a_sram_addr), 5);
    chk("wr_sram_wdata", a_sram_wdata, 32'hDEAD_BEEF);
    chk("wr_rsp_idle",   32'(a_rsp_valid), 0);
    step();
    drive_a(1'b0, 10'd5, 32'h0, 4'hF);
    #1;
    chk("wr_rsp_valid", 32'(a_rsp_valid), 1);
    chk("wr_rsp_we",    32'(a_rsp_we), 1);
    chk("wr_rsp_rdata", a_rsp_rdata, 0);
    step();
    a_req_valid = 0;
    #1;
    chk("rd_rsp_valid", 32'(a_rsp_valid), 1);
    chk("rd_rsp_we",    32'(a_rsp_we), 0);
    chk("rd_rsp_rdata", a_rsp_rdata, 32'hDEAD_BEEF);
    step();
    chk("idle_valid", 32'(a_rsp_valid), 0);
    chk("idle_rdata", a_rsp_rdata, 0);

    // byte enables at addr 3
    drive_a(1'b1, 10'd3, 32'h1122_3344, 4'hF);
    step();
    drive_a(1'b1, 10'd3, 32'hAABB_CCDD, 4'h5);
    #1;
    chk("be_rsp1_we", 32'(a_rsp_we), 1);
    step();
    drive_a(1'b0, 10'd3, 32'h0, 4'hF);
    #1;
    chk("be_rsp2_we", 32'(a_rsp_we), 1);
    step();
    a_req_valid = 0;
    #1;
    chk("be_rd_valid", 32'(a_rsp_valid), 1);
    chk("be_rd_we",    32'(a_rsp_we), 0);
    chk("be_rd_rdata", a_rsp_rdata, 32'h11BB_33DD);
    step();

    // back-pressure: 4 reads with rsp_ready low
    a_rsp_ready = 0;
    drive_a(1'b0, 10'd10, 32'h0, 4'hF);
    #1;
    chk("bp_rdy0", 32'(a_req_ready), 1);
    step();
    drive_a(1'b0, 10'd11, 32'h0, 4'hF);
    #1;
    chk("bp_rdy1",   32'(a_req_ready), 1);
    chk("bp_hold_v", 32'(a_rsp_valid), 1);
    chk("bp_hold_d", a_rsp_rdata, 32'h5A00_000A);
    step();
    drive_a(1'b0, 10'd12, 32'h0, 4'hF);
    #1;
    chk("bp_rdy2",  32'(a_req_ready), 0);
    chk("bp_noreq", 32'(a_sram_req), 0);
    step();
    chk("bp_rdy3",  32'(a_req_ready), 0);
    chk("bp_hold2", a_rsp_rdata, 32'h5A00_000A);
    a_rsp_ready = 1;
    #1;
    chk("bp_drain_rdy", 32'(a_req_ready), 0);
    chk("bp_drain0",    a_rsp_rdata, 32'h5A00_000A);
    step();
    chk("bp_rdy_again", 32'(a_req_ready), 1);
    chk("bp_sram_addr", 32'(a_sram_addr), 12);
    chk("bp_drain1",    a_rsp_rdata, 32'h5A00_000B);
    step();
    drive_a(1'b0, 10'd13, 32'h0, 4'hF);
    #1;
    chk("bp_drain2", a_rsp_rdata, 32'h5A00_000C);
    step();
    a_req_valid = 0;
    #1;
    chk("bp_drain3", a_rsp_rdata, 32'h5A00_000D);
    step();
    chk("bp_empty", 32'(a_rsp_valid), 0);

    // reset with two outstanding reads
    a_rsp_ready = 0;
    drive_a(1'b0, 10'd1, 32'h0, 4'hF);
    step();
    drive_a(1'b0, 10'd2, 32'h0, 4'hF);
    step();
    a_req_valid = 0;
    #1;
    chk("mr_full", 32'(a_req_ready), 0);
    rst_n = 0;
    #1;
    chk("mr_ready", 32'(a_req_ready), 1);
    chk("mr_valid", 32'(a_rsp_valid), 0);
    chk("mr_rdata", a_rsp_rdata, 0);
    step();
    rst_n = 1;
    a_rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mr_no_stale", 32'(a_rsp_valid), 0);
      step();
    end

    // streaming on b: 16 back-to-back reads, responses 2 cycles later
    for (int i = 0; i < 18; i++) begin
      b_req_valid = (i < 16);
      b_req_addr  = AW'(i);
      #1;
      if (i < 16) chk("st_ready", 32'(b_req_ready), 1);
      if (i >= 2) begin
        chk("st_valid", 32'(b_rsp_valid), 1);
        chk("st_rdata", b_rsp_rdata, 32'hA000_0000 | (i - 2));
      end
      step();
    end
    chk("st_done", 32'(b_rsp_valid), 0);

    // random traffic on a against a scoreboard
    for (int i = 0; i < 16; i++) ref_mem[i] = m1[i];
    for (int c = 0; c < 400; c++) begin
      a_req_valid = 1'($urandom_range(0, 1));
      a_req_we    = 1'($urandom_range(0, 1));
      a_req_addr  = AW'($urandom_range(0, 15));
      a_req_wdata = $urandom;
      a_req_be    = BW'($urandom_range(0, 15));
      a_rsp_ready = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_ready", 32'(a_req_ready), 32'(exp_q.size() < 2));
      if (a_rsp_valid) begin
        chk("rnd_rsp_owed", 32'(exp_q.size() != 0), 1);
        if (a_rsp_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rnd_we",    32'(a_rsp_we), 32'(e[32]));
          chk("rnd_rdata", a_rsp_rdata, e[31:0]);
        end
      end
      if (a_req_valid && a_req_ready) begin
        if (a_req_we) begin
          for (int k = 0; k < BW; k++)
            if (a_req_be[k]) ref_mem[a_req_addr[3:0]][k*8 +: 8] = a_req_wdata[k*8 +: 8];
          exp_q.push_back({1'b1, 32'h0});
        end else begin
          exp_q.push_back({1'b0, ref_mem[a_req_addr[3:0]]});
        end
      end
      step();
    end
    a_req_valid = 0;
    a_rsp_ready = 1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (a_rsp_valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("drn_we",    32'(a_rsp_we), 32'(e[32]));
        chk("drn_rdata", a_rsp_rdata, e[31:0]);
      end
      step();
    end
    chk("rnd_all_answered", 32'(exp_q.size()), 0);
    chk("rnd_idle",         32'(a_rsp_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
